decim_comb_3rd: RTL

//  Decimate-by-DEC and third-order comb (differential delay 1): the back half of the sinc3/CIC

---
 rtl/decim_comb_3rd.sv | 105 ++++++++++
 1 files changed

// File: rtl/decim_comb_3rd.sv
// Decimate-by-DEC followed by a third-order comb (differential delay 1), then rounding,
// scaling by 2^-OUT_SHIFT and saturation to a signed OUT_W-bit output word.
module decim_comb_3rd #(
    parameter int IN_W      = 51,
    parameter int DEC       = 64,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic [IN_W-1:0]         xin,
    output logic signed [OUT_W-1:0] yout,
    output logic                    yout_valid,
    output logic                    settled,
    output logic                    sat
);

    localparam int CNT_W = $clog2(DEC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC - 1);

    // Round-half-up constant: 2^(OUT_SHIFT-1), or 0 when there is no shift.
    localparam logic signed [IN_W:0] RND   = ((IN_W+1)'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [IN_W:0] Q_MAX = ((IN_W+1)'(1) << (OUT_W - 1)) - (IN_W+1)'(1);
    localparam logic signed [IN_W:0] Q_MIN = -((IN_W+1)'(1) << (OUT_W - 1));

    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-1:0]  r_z1;
    logic [IN_W-1:0]  r_z2;
    logic [IN_W-1:0]  r_z3;
    logic [IN_W-1:0]  r_c3;
    logic             r_v1;
    logic [1:0]       r_nstb;

    logic                   w_dec_stb;
    logic [IN_W-1:0]        w_c1;
    logic [IN_W-1:0]        w_c2;
    logic [IN_W-1:0]        w_c3;
    logic signed [IN_W:0]   w_r;
    logic signed [IN_W:0]   w_q;

    assign w_dec_stb = clk_enable && (r_cnt == CNT_LAST);

    // Modular differences: integrator wrap-around cancels through the comb.
    assign w_c1 = xin  - r_z1;
    assign w_c2 = w_c1 - r_z2;
    assign w_c3 = w_c2 - r_z3;

    assign w_r = $signed({r_c3[IN_W-1], r_c3}) + RND;
    assign w_q = w_r >>> OUT_SHIFT;

    assign settled = (r_nstb == 2'd3);

    // NOTE: all state uses non-blocking assignments so every register samples the pre-edge
    // values of the others; blocking here would chain z1->z2->z3 within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_z1   <= '0;
            r_z2   <= '0;
            r_z3   <= '0;
            r_c3   <= '0;
            r_v1   <= 1'b0;
            r_nstb <= 2'd0;
        end else begin
            r_v1 <= w_dec_stb;
            if (clk_enable) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_dec_stb) begin
                r_z1 <= xin;
                r_z2 <= w_c1;
                r_z3 <= w_c2;
                r_c3 <= w_c3;
                if (r_nstb != 2'd3) begin
                    r_nstb <= r_nstb + 2'd1;
                end
            end
        end
    end

    // Output stage runs on every clock so a capture always lands one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            yout       <= '0;
            yout_valid <= 1'b0;
            sat        <= 1'b0;
        end else begin
            yout_valid <= r_v1;
            sat        <= 1'b0;
            if (r_v1) begin
                if (w_q > Q_MAX) begin
                    yout <= Q_MAX[OUT_W-1:0];
                    sat  <= 1'b1;
                end else if (w_q < Q_MIN) begin
                    yout <= Q_MIN[OUT_W-1:0];
                    sat  <= 1'b1;
                end else begin
                    yout <= w_q[OUT_W-1:0];
                end
            end
        end
    end

endmodule
